// File: rtl/jpeg_byte_stuffer_if.sv
// Byte-stream bus for jpeg_byte_stuffer: compressor side in, ready/valid consumer side out.
// The slave modport is the stuffer's view; master is the driver/consumer view.
`timescale 1ns/1ps
interface jpeg_byte_stuffer_if #(
   parameter int FIFO_DEPTH_LOG2 = 4
);
   logic                     in_valid;
   logic [7:0]               in_data;
   logic                     frame_end;
   logic                     out_valid;
   logic [7:0]               out_data;
   logic                     out_ready;
   logic                     overflow;
   logic [FIFO_DEPTH_LOG2:0] level;

   modport master (
      output in_valid, in_data, frame_end, out_ready,
      input  out_valid, out_data, overflow, level
   );

   modport slave (
      input  in_valid, in_data, frame_end, out_ready,
      output out_valid, out_data, overflow, level
   );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// JPEG byte stuffer: inserts 00 after every FF data byte and buffers into a 2-write/1-read FIFO.
// Define JPEG_STUFFER_EOI_EN to append the FF D9 EOI marker after each frame_end.
`timescale 1ns/1ps
module jpeg_byte_stuffer #(
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   jpeg_byte_stuffer_if.slave    bus
);
   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int LW    = FIFO_DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_nxt;
   logic [LW-1:0] free;
   logic [LW-1:0] push_cnt;
   logic          overflow_q;
   logic          is_ff;
   logic          take_one;
   logic          take_two;
   logic          pop;
   logic          eoi_write;
   logic [7:0]    byte0;
   logic [7:0]    byte1;

   // free is taken from the pre-cycle level, so a same-cycle pop never makes room
   always_comb begin
      free      = LW'(DEPTH) - level_q;
      is_ff     = (bus.in_data == 8'hFF);
      take_one  = bus.in_valid && !is_ff && (free >= LW'(1));
      take_two  = bus.in_valid &&  is_ff && (free >= LW'(2));
      pop       = (level_q != '0) && bus.out_ready;
      byte0     = bus.in_data;
      byte1     = 8'h00;
      push_cnt  = '0;
      if (take_one) begin
         push_cnt = LW'(1);
      end else if (take_two) begin
         push_cnt = LW'(2);
      end else if (eoi_write) begin
         push_cnt = LW'(2);
         byte0    = 8'hFF;
         byte1    = 8'hD9;
      end
      level_nxt = level_q + push_cnt - LW'(pop);
   end

`ifdef JPEG_STUFFER_EOI_EN
   typedef enum logic {EOI_IDLE, EOI_PENDING} eoi_state_t;
   eoi_state_t eoi_state;

   // Data bytes win; the marker goes out on the first idle input cycle with room for both bytes
   assign eoi_write = (eoi_state == EOI_PENDING) && !bus.in_valid && (free >= LW'(2));

   always_ff @(posedge clock) begin
      if (reset) begin
         eoi_state <= EOI_IDLE;
      end else begin
         case (eoi_state)
            EOI_IDLE:    if (bus.frame_end) eoi_state <= EOI_PENDING;
            EOI_PENDING: if (eoi_write)     eoi_state <= EOI_IDLE;
            default:                        eoi_state <= EOI_IDLE;
         endcase
      end
   end
`else
   logic unused_frame_end;
   assign eoi_write        = 1'b0;
   assign unused_frame_end = bus.frame_end;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + AW'(push_cnt);
         rd_ptr  <= rd_ptr + AW'(pop);
         level_q <= level_nxt;
         if (bus.in_valid && !take_one && !take_two) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Second byte goes to the next slot, wrapping to slot 0 when the first lands in the last slot
   always_ff @(posedge clock) begin
      if (push_cnt != '0) begin
         mem[wr_ptr] <= byte0;
      end
      if (push_cnt == LW'(2)) begin
         mem[wr_ptr + AW'(1)] <= byte1;
      end
   end

   assign bus.out_valid = (level_q != '0);
   assign bus.out_data  = mem[rd_ptr];
   assign bus.overflow  = overflow_q;
   assign bus.level     = level_q;
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Bench for jpeg_byte_stuffer: table-driven cycle vectors plus hand sequences, with a byte scoreboard.
// EOI expectations follow whether JPEG_STUFFER_EOI_EN is defined for the build.
`timescale 1ns/1ps
module tb_jpeg_byte_stuffer;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   jpeg_byte_stuffer_if #(.FIFO_DEPTH_LOG2(2)) sb ();
   jpeg_byte_stuffer_if #(.FIFO_DEPTH_LOG2(4)) bb ();

   jpeg_byte_stuffer #(.FIFO_DEPTH_LOG2(2)) dut_s (.clock(clock), .reset(reset), .bus(sb));
   jpeg_byte_stuffer #(.FIFO_DEPTH_LOG2(4)) dut_b (.clock(clock), .reset(reset), .bus(bb));

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      bit         rst;
      bit         v;
      logic [7:0] d;
      bit         rdy;
      int         lvl;
      bit         ovf;
      int         np;
      logic [7:0] b0;
      logic [7:0] b1;
   } vec_t;
   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit rst, input bit v, input logic [7:0] d, input bit rdy,
                               input int lvl, input bit ovf, input int np,
                               input logic [7:0] b0, input logic [7:0] b1);
      vec_t e;
      e.rst = rst; e.v = v; e.d = d; e.rdy = rdy; e.lvl = lvl; e.ovf = ovf;
      e.np = np; e.b0 = b0; e.b1 = b1;
      tbl.push_back(e);
   endfunction

   task automatic cyc(input logic v, input logic [7:0] d, input logic fe, input logic rdy);
      sb.in_valid  = v;
      sb.in_data   = d;
      sb.frame_end = fe;
      sb.out_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   // Output monitor on the small FIFO: pops compare against the scoreboard, stalls must hold data
   logic       stall_prev = 1'b0;
   logic [7:0] held = 8'h00;
   always @(negedge clock) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("hold_data", {sb.out_valid, sb.out_data}, {1'b1, held});
         if (sb.out_valid && sb.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_byte: got %0h, expected no byte", sb.out_data);
            end else begin
               check("out_data", sb.out_data, exp_q.pop_front());
            end
         end
         stall_prev = sb.out_valid && !sb.out_ready;
         held       = sb.out_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t e;
      logic rdy;
      logic [7:0] b;
      int waited;
      int vcount;

      reset = 1'b1;
      sb.in_valid = 0; sb.in_data = 0; sb.frame_end = 0; sb.out_ready = 0;
      bb.in_valid = 0; bb.in_data = 0; bb.frame_end = 0; bb.out_ready = 0;
      @(posedge clock);
      #1;

      // rst v  d     rdy lvl ovf np b0     b1
      add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 1, 8'h12, 1, 1, 0, 1, 8'h12, 8'h00);
      add(0, 1, 8'hFF, 1, 2, 0, 2, 8'hFF, 8'h00);
      add(0, 1, 8'h34, 1, 2, 0, 1, 8'h34, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
      // Overflow on FF with one free slot; only 01 02 03 come out
      add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 1, 8'h01, 0, 1, 0, 1, 8'h01, 8'h00);
      add(0, 1, 8'h02, 0, 2, 0, 1, 8'h02, 8'h00);
      add(0, 1, 8'h03, 0, 3, 0, 1, 8'h03, 8'h00);
      add(0, 1, 8'hFF, 0, 3, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 2, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00);
      // Pointers to slot 3, then FF/00 straddles the wrap
      add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 1, 8'hA1, 0, 1, 0, 1, 8'hA1, 8'h00);
      add(0, 1, 8'hA2, 0, 2, 0, 1, 8'hA2, 8'h00);
      add(0, 1, 8'hA3, 0, 3, 0, 1, 8'hA3, 8'h00);
      add(0, 0, 8'h00, 1, 2, 0, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 1, 8'hFF, 0, 2, 0, 2, 8'hFF, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
      // FF fits exactly into two free slots; full FIFO with pop still drops a plain byte
      add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 1, 8'hC1, 0, 1, 0, 1, 8'hC1, 8'h00);
      add(0, 1, 8'hC2, 0, 2, 0, 1, 8'hC2, 8'h00);
      add(0, 1, 8'hFF, 0, 4, 0, 2, 8'hFF, 8'h00);
      add(0, 1, 8'hC3, 1, 3, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 2, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00);
      add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00);

      for (int i = 0; i < tbl.size(); i++) begin
         e = tbl[i];
         if (e.rst) begin
            reset = 1'b1;
            exp_q.delete();
         end else begin
            reset = 1'b0;
            if (e.np >= 1) exp_q.push_back(e.b0);
            if (e.np == 2) exp_q.push_back(e.b1);
         end
         cyc(e.v, e.d, 1'b0, e.rdy);
         check($sformatf("row%0d_level", i), sb.level, e.lvl);
         check($sformatf("row%0d_overflow", i), sb.overflow, e.ovf);
         check($sformatf("row%0d_out_valid", i), sb.out_valid, (e.lvl != 0));
      end
      check("table_drained", exp_q.size(), 0);

      // frame_end with a data byte, then a second frame_end while the EOI is still pending
      reset = 1'b1;
      exp_q.delete();
      cyc(0, 8'h00, 0, 0);
      reset = 1'b0;
      exp_q.push_back(8'hAB);
      cyc(1, 8'hAB, 1, 1);
      check("eoi_level_after_ab", sb.level, 1);
`ifdef JPEG_STUFFER_EOI_EN
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD9);
      cyc(0, 8'h00, 0, 1);
      check("eoi_level_after_marker", sb.level, 2);
`endif
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1);
      check("eoi1_level", sb.level, 0);
      check("eoi1_drained", exp_q.size(), 0);
      exp_q.push_back(8'hCD);
      cyc(1, 8'hCD, 1, 1);
      exp_q.push_back(8'hEF);
      cyc(1, 8'hEF, 1, 1);
`ifdef JPEG_STUFFER_EOI_EN
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD9);
`endif
      for (int i = 0; i < 8; i++) cyc(0, 8'h00, 0, 1);
      check("eoi2_level", sb.level, 0);
      check("eoi2_drained", exp_q.size(), 0);
      check("eoi2_overflow", sb.overflow, 0);

      // Backpressure: ready toggles every cycle, one byte offered every second cycle
      reset = 1'b1;
      exp_q.delete();
      cyc(0, 8'h00, 0, 0);
      reset = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         b = (i == 5) ? 8'hFF : 8'h40 + 8'(i);
         exp_q.push_back(b);
         if (b == 8'hFF) exp_q.push_back(8'h00);
         cyc(1, b, 0, rdy);
         rdy = ~rdy;
         cyc(0, 8'h00, 0, rdy);
         rdy = ~rdy;
      end
      waited = 0;
      while ((sb.level != 0) && (waited < 40)) begin
         cyc(0, 8'h00, 0, rdy);
         rdy = ~rdy;
         waited++;
      end
      check("bp_level", sb.level, 0);
      check("bp_drained", exp_q.size(), 0);
      check("bp_overflow", sb.overflow, 0);
      sb.out_ready = 1'b0;

      // Reset with five bytes queued and an EOI pending on the 16-entry instance
      bb.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bb.in_valid  = 1'b1;
         bb.in_data   = 8'(i);
         bb.frame_end = (i == 4);
         @(posedge clock);
         #1;
      end
      bb.in_valid  = 1'b0;
      bb.frame_end = 1'b0;
      check("big_level_before_reset", bb.level, 5);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("big_out_valid_after_reset", bb.out_valid, 0);
      check("big_level_after_reset", bb.level, 0);
      bb.out_ready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         if (bb.out_valid) vcount++;
      end
      check("big_no_eoi_after_reset", vcount, 0);
      check("big_overflow", bb.overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
